nanomamba_wt_arbiter: RTL and testbench

- Shares the single INT8 weight-SRAM port among several requesters: host loader (regfile), SA-SSM compute and classifier.
- Reads use a round-robin arbiter with burst locking, so one requester holds the port until it flags its last beat.
- Host writes take cycle-level priority over reads.
- Sits between the requesters and nanomamba_weight_sram (1-cycle registered read); it also detects stalled bursts and out-of-range addresses.

---
 rtl/nanomamba_wt_arbiter.sv | 162 ++++++++++++++++
 tb/tb_nanomamba_wt_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanomamba_wt_arbiter.sv
// rtl/nanomamba_wt_arbiter.sv - weight-SRAM port arbiter: burst-locked round-robin reads, priority host writes
module nanomamba_wt_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4736,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic [N_REQ-1:0]        rd_req,
   input  logic [N_REQ*ADDR_W-1:0] rd_addr,
   input  logic [N_REQ-1:0]        rd_last,
   output logic [N_REQ-1:0]        rd_gnt,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   input  logic                    wr_req,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_ack,
   output logic                    sram_rd_en,
   output logic [ADDR_W-1:0]       sram_rd_addr,
   input  logic [DATA_W-1:0]       sram_rd_data,
   output logic                    sram_wr_en,
   output logic [ADDR_W-1:0]       sram_wr_addr,
   output logic [DATA_W-1:0]       sram_wr_data,
   output logic                    busy,
   output logic [1:0]              owner,
   output logic                    err_timeout,
   output logic                    err_oob
);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] RR_INIT = 2'(N_REQ - 1);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        rr_q, rr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              vld_q, vld_oob_q;
   logic              to_fire;
   logic              beat;
   logic              rd_oob, wr_oob;
   logic [ADDR_W-1:0] own_addr;
   logic [1:0]        win, scan_idx;
   logic              hit;

   assign own_addr = rd_addr[int'(owner_q)*ADDR_W +: ADDR_W];
   assign rd_oob   = {1'b0, own_addr} >= DEPTH_X;
   assign wr_oob   = {1'b0, wr_addr} >= DEPTH_X;
   // clr outranks a beat in the same cycle, and any host write stalls the owner
   assign beat     = (state_q == ST_LOCK) && rd_req[owner_q] && !wr_req && !clr;

   // first requester after rr wins; scanning backwards lets the nearest one overwrite
   always_comb begin
      win      = '0;
      hit      = 1'b0;
      scan_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         scan_idx = 2'((int'(rr_q) + k) % N_REQ);
         if (rd_req[scan_idx]) begin
            win = scan_idx;
            hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_q <= ST_IDLE;
      else if (clr) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      to_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (hit) begin
               state_d = ST_LOCK;
               owner_d = win;
            end
         end
         ST_LOCK: begin
            if (beat) begin
               cnt_d = '0;
               if (rd_last[owner_q]) begin
                  state_d = ST_IDLE;
                  rr_d    = owner_q;
               end
            end else if (!wr_req) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  rr_d    = owner_q;
                  cnt_d   = '0;
                  to_fire = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_gnt          = '0;
      rd_gnt[owner_q] = beat;
      rd_valid        = '0;
      if (vld_q) rd_valid[owner_q] = 1'b1;
      rd_data      = (vld_q && !vld_oob_q) ? sram_rd_data : '0;
      sram_rd_en   = beat && !rd_oob;
      sram_rd_addr = sram_rd_en ? own_addr : '0;
      wr_ack       = wr_req;
      sram_wr_en   = wr_req && !wr_oob;
      sram_wr_addr = wr_req ? wr_addr : '0;
      sram_wr_data = wr_req ? wr_data : '0;
      busy         = (state_q == ST_LOCK);
      owner        = owner_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= '0;
         rr_q        <= RR_INIT;
         cnt_q       <= '0;
         vld_q       <= 1'b0;
         vld_oob_q   <= 1'b0;
         err_timeout <= 1'b0;
         err_oob     <= 1'b0;
      end else if (clr) begin
         owner_q     <= '0;
         rr_q        <= RR_INIT;
         cnt_q       <= '0;
         vld_q       <= 1'b0;
         vld_oob_q   <= 1'b0;
         err_timeout <= 1'b0;
         err_oob     <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         vld_q     <= beat;
         vld_oob_q <= beat && rd_oob;
         if (to_fire) err_timeout <= 1'b1;
         if ((beat && rd_oob) || (wr_req && wr_oob)) err_oob <= 1'b1;
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_hold
      a_hold: assert property (@(posedge clk) disable iff (!rst_n || clr)
         (rd_req[i] && !rd_gnt[i]) |=> (rd_req[i] && $stable(rd_addr[i*ADDR_W +: ADDR_W])));
   end
endmodule

// File: tb/tb_nanomamba_wt_arbiter.sv
// tb/tb_nanomamba_wt_arbiter.sv - self-checking bench for nanomamba_wt_arbiter
module tb_nanomamba_wt_arbiter;
   localparam int N_REQ = 3, ADDR_W = 13, DATA_W = 8, DEPTH = 4736, TIMEOUT = 64;

   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic [N_REQ-1:0]        rd_req = '0, rd_last = '0;
   logic [N_REQ*ADDR_W-1:0] rd_addr = '0;
   logic [N_REQ-1:0]        rd_gnt, rd_valid;
   logic [DATA_W-1:0]       rd_data;
   logic                    wr_req = 1'b0;
   logic [ADDR_W-1:0]       wr_addr = '0;
   logic [DATA_W-1:0]       wr_data = '0;
   logic                    wr_ack, sram_rd_en, sram_wr_en;
   logic [ADDR_W-1:0]       sram_rd_addr, sram_wr_addr;
   logic [DATA_W-1:0]       sram_rd_data = '0, sram_wr_data;
   logic                    busy, err_timeout, err_oob;
   logic [1:0]              owner;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   nanomamba_wt_arbiter dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
      .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
      .busy(busy), .owner(owner), .err_timeout(err_timeout), .err_oob(err_oob)
   );

   function automatic logic [7:0] pat(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   // weight SRAM: one-cycle registered read
   logic [7:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
   always @(posedge clk) begin
      if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
      if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: lock flag, owner, rr pointer, idle-cycle count, one pending read
   logic [7:0] mm [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mm[i] = pat(i);
   bit m_lock, m_vld, m_eto, m_eoob;
   int m_owner, m_rr, m_idle, m_vld_own;
   logic [7:0] m_vld_data;
   logic [ADDR_W-1:0] c_a;
   bit c_g, c_oob, c_found;
   int c_w;

   function void model_reset();
      m_lock = 0; m_owner = 0; m_rr = N_REQ - 1; m_idle = 0;
      m_vld = 0; m_vld_own = 0; m_vld_data = 0; m_eto = 0; m_eoob = 0;
   endfunction

   initial model_reset();

   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
         chk("rst_gnt", rd_gnt, 0);
         chk("rst_valid", rd_valid, 0);
         chk("rst_data", rd_data, 0);
         chk("rst_rd_en", sram_rd_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_owner", owner, 0);
         chk("rst_err", {err_timeout, err_oob}, 0);
      end else begin
         c_a   = rd_addr[m_owner*ADDR_W +: ADDR_W];
         c_oob = (int'(c_a) >= DEPTH);
         c_g   = m_lock && rd_req[m_owner] && !wr_req && !clr;
         chk("m_gnt", rd_gnt, c_g ? (1 << m_owner) : 0);
         chk("m_rd_en", sram_rd_en, c_g && !c_oob);
         if (c_g && !c_oob) chk("m_rd_addr", sram_rd_addr, c_a);
         chk("m_valid", rd_valid, m_vld ? (1 << m_vld_own) : 0);
         chk("m_data", rd_data, m_vld ? m_vld_data : 0);
         chk("m_wr_ack", wr_ack, wr_req);
         chk("m_wr_en", sram_wr_en, wr_req && (int'(wr_addr) < DEPTH));
         if (wr_req) chk("m_wr_addr_data", {sram_wr_addr, sram_wr_data}, {wr_addr, wr_data});
         chk("m_busy", busy, m_lock);
         chk("m_owner", owner, m_owner);
         chk("m_err_timeout", err_timeout, m_eto);
         chk("m_err_oob", err_oob, m_eoob);
         if (clr) model_reset();
         else begin
            if ((c_g && c_oob) || (wr_req && int'(wr_addr) >= DEPTH)) m_eoob = 1;
            m_vld = c_g;
            m_vld_own = m_owner;
            m_vld_data = (c_g && !c_oob) ? mm[c_a] : 8'h00;
            if (wr_req && int'(wr_addr) < DEPTH) mm[wr_addr] = wr_data;
            if (!m_lock) begin
               m_idle = 0;
               c_found = 0; c_w = 0;
               for (int k = 1; k <= N_REQ; k++)
                  if (!c_found && rd_req[(m_rr + k) % N_REQ]) begin
                     c_found = 1; c_w = (m_rr + k) % N_REQ;
                  end
               if (c_found) begin m_lock = 1; m_owner = c_w; end
            end else if (c_g) begin
               m_idle = 0;
               if (rd_last[m_owner]) begin m_lock = 0; m_rr = m_owner; end
            end else if (!wr_req) begin
               m_idle++;
               if (m_idle == TIMEOUT) begin
                  m_lock = 0; m_rr = m_owner; m_eto = 1; m_idle = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int i, input bit r, input int addr, input bit last);
      rd_req[i] = r;
      rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
      rd_last[i] = last;
   endtask

   int ng[N_REQ];
   int exp_order[6];
   int gi, b;
   bit w;
   logic [7:0] got[$];

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single requester, 4-beat burst
      set_req(1, 1, 100, 0);
      @(negedge clk); chk("t1_bubble_gnt", rd_gnt, 0); chk("t1_bubble_busy", busy, 0);
      for (int k = 0; k < 4; k++) begin
         tick(); set_req(1, 1, 100 + k, k == 3);
         @(negedge clk);
         chk("t1_gnt", rd_gnt, 3'b010);
         if (k > 0) begin
            chk("t1_valid", rd_valid, 3'b010);
            chk("t1_data", rd_data, pat(100 + k - 1));
         end
         if (k == 1) chk("t1_data_lit", rd_data, 8'hBF);
      end
      tick(); set_req(1, 0, 0, 0);
      @(negedge clk);
      chk("t1_last_valid", rd_valid, 3'b010);
      chk("t1_last_data", rd_data, 8'hD4);
      chk("t1_busy_fall", busy, 0);

      // three single-beat requesters from a cleared state
      tick(); clr = 1'b1;
      tick(); clr = 1'b0;
      set_req(0, 1, 200, 1); set_req(1, 1, 300, 1); set_req(2, 1, 400, 1);
      exp_order = '{0, 1, 2, 0, 1, 2};
      ng = '{0, 0, 0};
      gi = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 2 == 0) chk("t2_bubble", rd_gnt, 0);
         else begin
            chk("t2_order", rd_gnt, 1 << exp_order[gi]);
            gi++;
         end
         for (int i = 0; i < N_REQ; i++) if (rd_gnt[i]) ng[i]++;
         tick();
         for (int i = 0; i < N_REQ; i++) if (ng[i] == 2) rd_req[i] = 1'b0;
      end

      // 8-beat burst on requester 2 with two write stalls
      set_req(2, 1, 500, 0);
      @(negedge clk); chk("t3_bubble", rd_gnt, 0);
      tick();
      b = 0;
      for (int c = 0; c < 10; c++) begin
         w = (c == 3 || c == 6);
         set_req(2, 1, 500 + b, b == 7);
         wr_req  = w;
         wr_addr = (c == 3) ? 13'd506 : 13'd4000;
         wr_data = (c == 3) ? 8'h5A : 8'h11;
         @(negedge clk);
         if (rd_valid[2]) got.push_back(rd_data);
         if (w) begin
            chk("t3_stall_gnt", rd_gnt, 0);
            chk("t3_wr_ack", wr_ack, 1);
            chk("t3_wr_en", sram_wr_en, 1);
            chk("t3_owner", owner, 2);
         end else chk("t3_gnt", rd_gnt, 3'b100);
         tick();
         if (!w) b++;
      end
      wr_req = 1'b0; set_req(2, 0, 0, 0);
      @(negedge clk);
      if (rd_valid[2]) got.push_back(rd_data);
      chk("t3_nvalid", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk("t3_order", got[i], (i == 6) ? 8'h5A : pat(500 + i));

      // lock on requester 1, then let it go quiet until timeout
      tick();
      set_req(1, 1, 50, 0);
      @(negedge clk); chk("t4_bubble", rd_gnt, 0);
      tick();
      @(negedge clk); chk("t4_beat", rd_gnt, 3'b010);
      tick();
      set_req(1, 0, 0, 0); set_req(0, 1, 60, 1);
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 64) begin chk("t4_busy64", busy, 1); chk("t4_noerr64", err_timeout, 0); end
         tick();
      end
      @(negedge clk);
      chk("t4_released", busy, 0); chk("t4_err", err_timeout, 1);
      tick();
      @(negedge clk); chk("t4_req0", rd_gnt, 3'b001);
      tick(); set_req(0, 0, 0, 0);

      // out-of-range beat and write, then clr colliding with a beat
      set_req(0, 1, 4736, 1);
      @(negedge clk); chk("t5_bubble", rd_gnt, 0);
      tick();
      @(negedge clk); chk("t5_gnt", rd_gnt, 3'b001); chk("t5_rd_en", sram_rd_en, 0);
      tick(); set_req(0, 0, 0, 0);
      @(negedge clk);
      chk("t5_valid", rd_valid, 3'b001); chk("t5_data0", rd_data, 0); chk("t5_err", err_oob, 1);
      tick(); wr_req = 1'b1; wr_addr = 13'd5000; wr_data = 8'h77;
      @(negedge clk); chk("t5_wr_ack", wr_ack, 1); chk("t5_wr_drop", sram_wr_en, 0);
      tick(); wr_req = 1'b0;
      set_req(1, 1, 10, 0);
      @(negedge clk);
      tick(); clr = 1'b1;
      @(negedge clk); chk("t5_clr_gnt", rd_gnt, 0); chk("t5_clr_rd_en", sram_rd_en, 0);
      tick(); clr = 1'b0; set_req(1, 1, 10, 1);
      @(negedge clk);
      chk("t5_oob_clr", err_oob, 0); chk("t5_busy_clr", busy, 0); chk("t5_to_clr", err_timeout, 0);
      tick();
      @(negedge clk); chk("t5_regrant", rd_gnt, 3'b010);
      tick(); set_req(1, 0, 0, 0);

      // asynchronous reset in the middle of a 4-beat burst
      set_req(0, 1, 700, 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tick(); set_req(0, 1, 700 + k, 0);
         @(negedge clk); chk("t6_gnt", rd_gnt, 3'b001);
      end
      tick();
      chk("t6_pending", rd_valid, 3'b001);
      rst_n = 1'b0;
      set_req(0, 1, 800, 1); set_req(2, 1, 900, 1);
      #1;
      chk("t6_valid_kill", rd_valid, 0); chk("t6_busy_kill", busy, 0);
      chk("t6_gnt_kill", rd_gnt, 0); chk("t6_data_kill", rd_data, 0);
      @(negedge clk);
      tick(); rst_n = 1'b1;
      @(negedge clk); chk("t6_bubble", rd_gnt, 0);
      tick();
      @(negedge clk); chk("t6_req0_wins", rd_gnt, 3'b001);
      tick(); set_req(0, 0, 0, 0);
      @(negedge clk);
      tick();
      @(negedge clk); chk("t6_req2_next", rd_gnt, 3'b100);
      tick(); set_req(2, 0, 0, 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
